stepper_step_decoder: RTL
=========================

# stepper_step_decoder

Receive-side monitor for the 4-bit stepper coil bus that our motor drivers emit. It samples a coil bus, decodes the wave-drive phase sequence into step/direction events, and keeps a signed position count. It also reports motion activity and sequence errors. It sits beside each motor driver output, or on the pins of an external driver, so the color-sorting control logic can confirm that commanded motion actually happened.

## Interface
- `POS_W`, 16: width of the signed position counter.
- `IDLE_CYCLES`, 1000000: number of `clk` cycles without a step before `moving` deasserts; must be ≥ 2.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `coil`  input  4  coil bus; may be asynchronous to `clk`.
- `pos_clr`  input  1  synchronous clear of `position`.
- `err_clr`  input  1  synchronous clear of `err` and `err_code`.
- `step`  output  1  one-cycle pulse per decoded step.
- `dir`  output  1  direction of the last step (1 = forward, 0 = backward).
- `position`  output  POS_W  signed step count.
- `moving`  output  1  high while steps arrive within `IDLE_CYCLES`.
- `err`  output  1  sticky error flag.
- `err_code`  output  2  code of the first error since the last clear: 01 = illegal pattern, 10 = skipped phase.

## Operation
- **Synchronizer:** `coil` passes through a 2-flop synchronizer to produce `coil_s`. A held register `coil_h` holds the previous `coil_s`. Decoding acts only when `coil_s != coil_h`.
- **Legal patterns:**
  - 0001 = phase 0, 0010 = phase 1, 0100 = phase 2, 1000 = phase 3.
  - 0000 = coils off.
  - Every other value is illegal.
- **State:** `last_phase` (2 bits) and `last_valid` (1 bit). `last_valid` is set once any phase has been seen.
- **On a change to a legal phase p:**
  - If `last_valid` = 0: capture p, set `last_valid`, no step.
  - Else, let d = (p − `last_phase`) mod 4:
    - d = 1: forward step. `step` = 1, `dir` = 1, `position` + 1.
    - d = 3: backward step. `step` = 1, `dir` = 0, `position` − 1.
    - d = 2: skip error (code 10), no step.
  - In all cases `last_phase` ← p.
- **On a change to 0000:** no step; `last_phase` and `last_valid` are kept, so resuming on an adjacent phase counts as a step.
- **On a change to an illegal pattern:** error code 01, no step, `last_phase` is unchanged.
- **Errors:**
  - `err` is set on any error and stays set until `err_clr`.
  - `err_code` latches only when `err` = 0.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: `err` = 1 and `err_code` = the new code.
- **Position:**
  - Wraps in two's complement; no saturation.
  - If `pos_clr` and a step occur in the same cycle, the clear wins (`position` = 0), but `step` and `dir` still update.
- **Idle counter:**
  - Resets to 0 on each step and saturates at `IDLE_CYCLES` − 1.
  - `moving` = 1 on a step cycle.
  - `moving` = 0 once the counter reaches `IDLE_CYCLES` − 1.

## Timing
- **Reset values** (asserting `rst` immediately forces all of these):
  - `step` = 0, `dir` = 0, `position` = 0, `moving` = 0, `err` = 0, `err_code` = 00.
  - Synchronizer flops, `coil_h`, `last_phase` = 0; `last_valid` = 0; idle counter = 0.
  - The first legal phase after reset never produces a step.
- **Latency:**
  - A `coil` change sampled at edge N produces `step` (and the `position`/`dir` update) in the cycle after edge N+2, i.e. registered 3 cycles after sampling.
  - `position`, `dir`, `moving` and `step` update on the same edge.
  - Errors assert with the same 3-cycle latency.
- **Throughput:** `coil` must be stable for at least 2 cycles per pattern. Faster changes are not guaranteed to be decoded.
- **Control inputs:** `pos_clr` and `err_clr` take effect on the next edge.
- **Idle timeout:** `moving` falls exactly `IDLE_CYCLES` − 1 cycles after the last step cycle.

## Structure
- **`stepper_pkg`:**
  - Coil pattern constants `COIL_PH0`…`COIL_PH3`, `COIL_OFF`.
  - Error codes `ERR_NONE`, `ERR_ILLEGAL`, `ERR_SKIP`.
  - Direction constants `DIR_FWD`, `DIR_REV`.
  - Shared with `stepper_motor_driver`.
- **Sub-module:** one, `coil_sync` (parameterised-width 2-flop synchronizer with async active-low reset). All decode, position and idle logic stays in the top module.

## Test plan
- Reset, then `coil` = 0001 held 20 cycles → no `step`, `position` = 0, `moving` = 0, `err` = 0.
- Forward sequence 0001, 0010, 0100, 1000, 0001, 10 cycles each → 4 `step` pulses, each 3 cycles after its change, `dir` = 1, `position` = 4.
- From 0001: reverse 1000, 0100 → 2 steps, `dir` = 0, `position` = 16'hFFFE. Then 0000 followed by 1000 → 1 forward step, `position` = 16'hFFFF.
- Error latching and clearing:
  - 0001 → 0100 → `err` = 1, `err_code` = 10, `position` unchanged.
  - Then 0110 → `err_code` stays 10.
  - `err_clr` → `err` = 0, `err_code` = 00.
  - `err_clr` in the same cycle as the error from 0011 → `err` = 1, `err_code` = 01.
- Idle timeout and clear priority:
  - With `IDLE_CYCLES` = 16: after one step, `moving` = 1 for 15 cycles, then 0.
  - `pos_clr` coincident with a step → `position` = 0 and `step` = 1.
- Reset mid-operation: `rst` low during an active forward sequence → all outputs 0 asynchronously. After release, the first phase produces no step.

Source files
------------

// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the stepper coil bus: wave-drive coil patterns, error
// codes, direction encoding and a helper that classifies a coil pattern.
// Used by stepper_step_decoder and stepper_motor_driver.
// -----------------------------------------------------------------------------
package stepper_pkg;

  // Wave-drive patterns: exactly one coil energised per phase
  localparam logic [3:0] COIL_OFF = 4'b0000;
  localparam logic [3:0] COIL_PH0 = 4'b0001;
  localparam logic [3:0] COIL_PH1 = 4'b0010;
  localparam logic [3:0] COIL_PH2 = 4'b0100;
  localparam logic [3:0] COIL_PH3 = 4'b1000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SKIP    = 2'b10;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Phase distance (new - last) mod 4 classification
  localparam logic [1:0] DELTA_FWD  = 2'd1;
  localparam logic [1:0] DELTA_SKIP = 2'd2;
  localparam logic [1:0] DELTA_REV  = 2'd3;

  typedef enum logic [1:0] {
    PAT_OFF,
    PAT_PHASE,
    PAT_ILLEGAL
  } coil_kind_t;

  typedef struct packed {
    coil_kind_t kind;
    logic [1:0] phase;
  } coil_dec_t;

  function automatic coil_dec_t decode_coil(input logic [3:0] pat);
    coil_dec_t r;
    r.kind  = PAT_ILLEGAL;
    r.phase = 2'd0;
    case (pat)
      COIL_OFF: r.kind = PAT_OFF;
      COIL_PH0: begin r.kind = PAT_PHASE; r.phase = 2'd0; end
      COIL_PH1: begin r.kind = PAT_PHASE; r.phase = 2'd1; end
      COIL_PH2: begin r.kind = PAT_PHASE; r.phase = 2'd2; end
      COIL_PH3: begin r.kind = PAT_PHASE; r.phase = 2'd3; end
      default:  r.kind = PAT_ILLEGAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/coil_sync.sv
// -----------------------------------------------------------------------------
// coil_sync
// Parameterised-width two-flop synchronizer for bringing the (possibly
// asynchronous) coil bus into the clk domain.
// Ports:
//   clk  in  1  sampling clock
//   rst  in  1  asynchronous, active-low reset (clears both stages)
//   d    in  W  asynchronous input
//   q    out W  synchronized output (2-cycle latency)
// -----------------------------------------------------------------------------
module coil_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepper_step_decoder.sv
// -----------------------------------------------------------------------------
// stepper_step_decoder
// Receive-side monitor for a 4-bit wave-drive stepper coil bus. Decodes phase
// transitions into step/direction events, keeps a signed position count,
// reports motion activity and latches the first sequence error.
// Ports:
//   clk       in  1      system clock
//   rst       in  1      asynchronous, active-low reset
//   coil      in  4      coil bus (may be asynchronous to clk)
//   pos_clr   in  1      synchronous clear of position (wins over a step)
//   err_clr   in  1      synchronous clear of err/err_code (loses to a new error)
//   step      out 1      one-cycle pulse per decoded step
//   dir       out 1      direction of last step (1 = forward)
//   position  out POS_W  signed step count, wraps
//   moving    out 1      high while steps arrive within IDLE_CYCLES
//   err       out 1      sticky error flag
//   err_code  out 2      first error since last clear (01 illegal, 10 skip)
// -----------------------------------------------------------------------------
module stepper_step_decoder
  import stepper_pkg::*;
#(
  parameter int POS_W       = 16,
  parameter int IDLE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              coil,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] position,
  output logic                    moving,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam int              CNT_W   = $clog2(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES - 1);

  logic [3:0]       coil_s;
  logic [3:0]       coil_h;
  logic [1:0]       last_phase;
  logic             last_valid;
  logic [CNT_W-1:0] idle_cnt;

  coil_dec_t        dec;
  logic             changed;
  logic [1:0]       delta;
  logic             phase_load;
  logic             step_fwd;
  logic             step_rev;
  logic             step_ev;
  logic             err_ev;
  logic [1:0]       err_new;
  logic [CNT_W-1:0] cnt_next;

  coil_sync #(
    .W (4)
  ) u_coil_sync (
    .clk (clk),
    .rst (rst),
    .d   (coil),
    .q   (coil_s)
  );

  // Decode only acts on the cycle coil_s differs from the previous sample, so a
  // held pattern is evaluated exactly once.
  always_comb begin
    dec        = decode_coil(coil_s);
    changed    = (coil_s != coil_h);
    delta      = dec.phase - last_phase;
    phase_load = 1'b0;
    step_fwd   = 1'b0;
    step_rev   = 1'b0;
    err_ev     = 1'b0;
    err_new    = ERR_NONE;
    if (changed) begin
      case (dec.kind)
        PAT_PHASE: begin
          phase_load = 1'b1;
          // First phase after reset only seeds last_phase. Delta 0 can occur
          // when returning to the same phase via off/illegal: not a step.
          if (last_valid) begin
            if (delta == DELTA_FWD) begin
              step_fwd = 1'b1;
            end else if (delta == DELTA_REV) begin
              step_rev = 1'b1;
            end else if (delta == DELTA_SKIP) begin
              err_ev  = 1'b1;
              err_new = ERR_SKIP;
            end
          end
        end
        PAT_ILLEGAL: begin
          err_ev  = 1'b1;
          err_new = ERR_ILLEGAL;
        end
        default: ;
      endcase
    end
    step_ev = step_fwd | step_rev;
  end

  always_comb begin
    cnt_next = idle_cnt;
    if (step_ev) begin
      cnt_next = '0;
    end else if (idle_cnt != CNT_MAX) begin
      cnt_next = idle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coil_h     <= '0;
      last_phase <= '0;
      last_valid <= 1'b0;
    end else begin
      coil_h <= coil_s;
      if (phase_load) begin
        last_phase <= dec.phase;
        last_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step     <= 1'b0;
      dir      <= 1'b0;
      position <= '0;
      idle_cnt <= '0;
      moving   <= 1'b0;
    end else begin
      step     <= step_ev;
      idle_cnt <= cnt_next;
      // moving only rises on a step; after reset the counter free-runs to
      // saturation without raising it.
      moving   <= step_ev | (moving & (cnt_next != CNT_MAX));
      if (step_fwd) begin
        dir <= DIR_FWD;
      end else if (step_rev) begin
        dir <= DIR_REV;
      end
      if (pos_clr) begin
        position <= '0;
      end else if (step_fwd) begin
        position <= position + POS_W'(1);
      end else if (step_rev) begin
        position <= position - POS_W'(1);
      end
    end
  end

  // A new error beats a simultaneous clear; the code only latches when no
  // error is pending (or is being cleared this cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (err_ev) begin
      err <= 1'b1;
      if (!err || err_clr) begin
        err_code <= err_new;
      end
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

endmodule
